// File: rtl/usb_pkt_rx_if.sv
// usb_pkt_rx_if: RX byte stream in, decoded packet results out.
// master = transceiver/SIE side, slave = the packet decoder.
interface usb_pkt_rx_if;
    logic [7:0]  rx_data;
    logic        rx_active;
    logic        rx_valid;
    logic        rx_error;
    logic [3:0]  pid;
    logic [10:0] token_data;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [10:0] byte_count;
    logic        pkt_end;
    logic        pkt_ok;
    logic        pkt_err;

    modport master (
        output rx_data, rx_active, rx_valid, rx_error,
        input  pid, token_data, data_out, data_valid,
        input  byte_count, pkt_end, pkt_ok, pkt_err
    );

    modport slave (
        input  rx_data, rx_active, rx_valid, rx_error,
        output pid, token_data, data_out, data_valid,
        output byte_count, pkt_end, pkt_ok, pkt_err
    );
endinterface

// File: rtl/usb_pkt_rx.sv
// usb_pkt_rx: USB receive packet decoder (PID, token CRC5, data CRC16, length).
// Define USB_PKT_RX_CRC16_EN to compile in data-packet CRC16 checking.
module usb_pkt_rx #(
    parameter int MAX_LEN = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    usb_pkt_rx_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_TOKEN,
        S_DATA,
        S_HSHK,
        S_WAIT_END,
        S_DONE
    } state_t;

    localparam logic [4:0]  CRC5_INIT = 5'h1F;
    localparam logic [4:0]  CRC5_RES  = 5'h06;
    localparam logic [10:0] BABBLE    = 11'(MAX_LEN + 2);
`ifdef USB_PKT_RX_CRC16_EN
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_RES  = 16'hB001;
`endif

    function automatic logic [4:0] f_crc5(
        input logic [4:0] c,
        input logic [7:0] d
    );
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 5'h14;
            else             r = r >> 1;
        end
        return r;
    endfunction

`ifdef USB_PKT_RX_CRC16_EN
    function automatic logic [15:0] f_crc16(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    state_t      r_state;
    logic        r_act_d;
    logic        r_boot;
    logic        r_quiet;
    logic        r_err;
    logic [3:0]  r_pid;
    logic [10:0] r_token;
    logic [7:0]  r_b1;
    logic [1:0]  r_tcnt;
    logic [4:0]  r_crc5;
`ifdef USB_PKT_RX_CRC16_EN
    logic [15:0] r_crc16;
`endif
    logic [7:0]  r_buf0;
    logic [7:0]  r_buf1;
    logic [1:0]  r_bfill;
    logic [10:0] r_dcnt;
    logic [10:0] r_byte_count;
    logic [7:0]  r_data_out;
    logic        r_data_valid;
    logic        r_pkt_end;
    logic        r_pkt_ok;
    logic        r_pkt_err;

    logic        w_rise;
    logic        w_byte;
    logic        w_pid_ok;
    logic        w_pid_err;
    logic        w_take_pid;
    logic        w_babble;
    logic        w_tok_bad;
    logic        w_dat_bad;
    state_t      w_pid_next;

    assign w_rise   = bus.rx_active & ~r_act_d;
    assign w_byte   = bus.rx_valid & bus.rx_active & ~bus.rx_error;
    assign w_pid_ok = (bus.rx_data[7:4] == ~bus.rx_data[3:0]);
    assign w_babble = (r_dcnt == BABBLE);
    assign w_tok_bad = (r_tcnt != 2'd2) || (r_crc5 != CRC5_RES);
`ifdef USB_PKT_RX_CRC16_EN
    assign w_dat_bad = (r_dcnt < 11'd2) || (r_crc16 != CRC16_RES);
`else
    assign w_dat_bad = (r_dcnt < 11'd2);
`endif

    // The PID byte may arrive in PID state or together with the rising edge.
    assign w_take_pid = w_byte &&
        ((r_state == S_PID) ||
         ((r_state == S_IDLE) && w_rise && !r_boot));

    // Decode the PID byte into the next state; bad or special PIDs park.
    always_comb begin
        w_pid_next = S_WAIT_END;
        if (w_pid_ok) begin
            unique case (bus.rx_data[1:0])
                2'b01:   w_pid_next = S_TOKEN;
                2'b11:   w_pid_next = S_DATA;
                2'b10:   w_pid_next = S_HSHK;
                default: w_pid_next = S_WAIT_END;
            endcase
        end
        w_pid_err = (w_pid_next == S_WAIT_END);
    end

    // Packet FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_act_d      <= 1'b0;
            r_boot       <= 1'b1;
            r_quiet      <= 1'b0;
            r_err        <= 1'b0;
            r_pid        <= 4'd0;
            r_token      <= 11'd0;
            r_b1         <= 8'd0;
            r_tcnt       <= 2'd0;
            r_crc5       <= CRC5_INIT;
`ifdef USB_PKT_RX_CRC16_EN
            r_crc16      <= CRC16_INIT;
`endif
            r_buf0       <= 8'd0;
            r_buf1       <= 8'd0;
            r_bfill      <= 2'd0;
            r_dcnt       <= 11'd0;
            r_byte_count <= 11'd0;
            r_data_out   <= 8'd0;
            r_data_valid <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_pkt_ok     <= 1'b0;
            r_pkt_err    <= 1'b0;
        end else begin
            r_act_d      <= bus.rx_active;
            r_boot       <= 1'b0;
            r_data_valid <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_pkt_ok     <= 1'b0;
            r_pkt_err    <= 1'b0;

            if (w_take_pid) begin
                r_byte_count <= 11'd0;
                r_dcnt       <= 11'd0;
                r_bfill      <= 2'd0;
                r_tcnt       <= 2'd0;
                r_crc5       <= CRC5_INIT;
`ifdef USB_PKT_RX_CRC16_EN
                r_crc16      <= CRC16_INIT;
`endif
                r_err        <= w_pid_err;
                r_state      <= w_pid_next;
                if (w_pid_ok) r_pid <= bus.rx_data[3:0];
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (r_boot && bus.rx_active) begin
                            r_state <= S_WAIT_END;
                            r_quiet <= 1'b1;
                        end else if (w_rise) begin
                            r_err   <= bus.rx_error;
                            r_state <= bus.rx_error ? S_WAIT_END : S_PID;
                        end
                    end
                    S_PID: begin
                        if (!bus.rx_active) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (bus.rx_error) begin
                            r_err   <= 1'b1;
                            r_state <= S_WAIT_END;
                        end
                    end
                    S_TOKEN: begin
                        if (!bus.rx_active) begin
                            r_err   <= r_err | w_tok_bad;
                            r_state <= S_DONE;
                        end else if (bus.rx_error) begin
                            r_err   <= 1'b1;
                            r_state <= S_WAIT_END;
                        end else if (w_byte) begin
                            if (r_tcnt == 2'd2) begin
                                r_err   <= 1'b1;
                                r_state <= S_WAIT_END;
                            end else begin
                                r_crc5 <= f_crc5(r_crc5, bus.rx_data);
                                r_tcnt <= r_tcnt + 2'd1;
                                if (r_tcnt == 2'd0) r_b1 <= bus.rx_data;
                                else r_token <= {bus.rx_data[2:0], r_b1};
                            end
                        end
                    end
                    S_DATA: begin
                        if (!bus.rx_active) begin
                            r_err   <= r_err | w_dat_bad;
                            r_state <= S_DONE;
                        end else if (bus.rx_error) begin
                            r_err   <= 1'b1;
                            r_state <= S_WAIT_END;
                        end else if (w_byte) begin
                            if (w_babble) begin
                                r_err   <= 1'b1;
                                r_state <= S_WAIT_END;
                            end else begin
                                r_dcnt <= r_dcnt + 11'd1;
`ifdef USB_PKT_RX_CRC16_EN
                                r_crc16 <= f_crc16(r_crc16, bus.rx_data);
`endif
                                if (r_bfill == 2'd2) begin
                                    r_data_out   <= r_buf0;
                                    r_data_valid <= 1'b1;
                                    r_byte_count <= r_byte_count + 11'd1;
                                    r_buf0       <= r_buf1;
                                    r_buf1       <= bus.rx_data;
                                end else if (r_bfill == 2'd1) begin
                                    r_buf1  <= bus.rx_data;
                                    r_bfill <= 2'd2;
                                end else begin
                                    r_buf0  <= bus.rx_data;
                                    r_bfill <= 2'd1;
                                end
                            end
                        end
                    end
                    S_HSHK: begin
                        if (!bus.rx_active) begin
                            r_state <= S_DONE;
                        end else if (bus.rx_error || w_byte) begin
                            r_err   <= 1'b1;
                            r_state <= S_WAIT_END;
                        end
                    end
                    S_WAIT_END: begin
                        if (!bus.rx_active) begin
                            if (r_quiet) begin
                                r_quiet <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_pkt_end <= 1'b1;
                        r_pkt_ok  <= ~r_err;
                        r_pkt_err <= r_err;
                        r_state   <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pid        = r_pid;
    assign bus.token_data = r_token;
    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.byte_count = r_byte_count;
    assign bus.pkt_end    = r_pkt_end;
    assign bus.pkt_ok     = r_pkt_ok;
    assign bus.pkt_err    = r_pkt_err;

endmodule

// File: tb/tb_usb_pkt_rx.sv
// tb_usb_pkt_rx: directed packets into two decoders (MAX_LEN 64 and 4).
// Expected values are hand-computed from the USB packet definitions.
module tb_usb_pkt_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_active;
    logic       s_valid;
    logic       s_err;

    int n_pass = 0;
    int n_tot  = 0;
    int n_end_a = 0;
    int n_end_b = 0;
    int n_bad  = 0;
    int e0;
    int e1;
    logic ok_a, er_a, ok_b, er_b;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] pk[$];
    logic [7:0] ex[$];

    always #5 clk = ~clk;

    usb_pkt_rx_if a_if();
    usb_pkt_rx_if b_if();

    assign a_if.rx_data   = s_data;
    assign a_if.rx_active = s_active;
    assign a_if.rx_valid  = s_valid;
    assign a_if.rx_error  = s_err;
    assign b_if.rx_data   = s_data;
    assign b_if.rx_active = s_active;
    assign b_if.rx_valid  = s_valid;
    assign b_if.rx_error  = s_err;

    usb_pkt_rx #(.MAX_LEN(64)) u_a (.i_clk(clk), .i_reset(rst), .bus(a_if));
    usb_pkt_rx #(.MAX_LEN(4))  u_b (.i_clk(clk), .i_reset(rst), .bus(b_if));

    // Collect payload bytes and end-of-packet status from both decoders.
    always @(negedge clk) begin
        if (a_if.data_valid) q_a.push_back(a_if.data_out);
        if (b_if.data_valid) q_b.push_back(b_if.data_out);
        if (a_if.pkt_end) begin
            n_end_a++;
            ok_a = a_if.pkt_ok;
            er_a = a_if.pkt_err;
            if (a_if.pkt_ok == a_if.pkt_err) n_bad++;
        end
        if (b_if.pkt_end) begin
            n_end_b++;
            ok_b = b_if.pkt_ok;
            er_b = b_if.pkt_err;
            if (b_if.pkt_ok == b_if.pkt_err) n_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send pk as one packet; err_at >= 0 inserts an rx_error pulse there.
    task automatic run(input int err_at);
        q_a.delete();
        q_b.delete();
        e0 = n_end_a;
        e1 = n_end_b;
        step();
        s_active = 1'b1;
        step();
        step();
        for (int i = 0; i < pk.size(); i++) begin
            if (i == err_at) begin
                s_err = 1'b1;
                step();
                s_err = 1'b0;
            end
            s_data  = pk[i];
            s_valid = 1'b1;
            step();
            s_valid = 1'b0;
            step();
        end
        s_active = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        rst = 1'b1;
        s_data = 8'd0;
        s_active = 1'b0;
        s_valid = 1'b0;
        s_err = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_pid", 32'(a_if.pid), 32'h0);
        chk("rst_token", 32'(a_if.token_data), 32'h0);
        chk("rst_count", 32'(a_if.byte_count), 32'h0);
        chk("rst_flags", {a_if.data_valid, a_if.pkt_end,
                          a_if.pkt_ok, a_if.pkt_err}, 32'h0);

        pk = {8'h2D, 8'h00, 8'h10};
        run(-1);
        chk("setup_pid", 32'(a_if.pid), 32'hD);
        chk("setup_token", 32'(a_if.token_data), 32'h000);
        chk("setup_ends", n_end_a - e0, 1);
        chk("setup_ok", {ok_a, er_a}, 32'b10);

        pk = {8'h2D, 8'h00, 8'h11};
        run(-1);
        chk("badcrc5_token", 32'(a_if.token_data), 32'h100);
        chk("badcrc5_err", {ok_a, er_a}, 32'b01);

        pk = {8'h2D, 8'h00, 8'h10, 8'h00};
        run(-1);
        chk("token3_err", {ok_a, er_a}, 32'b01);

        pk = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00,
              8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        ex = {8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        run(-1);
        chk("data0_pid", 32'(a_if.pid), 32'h3);
        chk("data0_nbytes", q_a.size(), 8);
        for (int i = 0; i < 8 && i < q_a.size(); i++)
            chk($sformatf("data0_b%0d", i), 32'(q_a[i]), 32'(ex[i]));
        chk("data0_count", 32'(a_if.byte_count), 32'd8);
        chk("data0_ok", {ok_a, er_a}, 32'b10);

        pk[10] = 8'h95;
        run(-1);
        chk("data0_flip_count", 32'(a_if.byte_count), 32'd8);
`ifdef USB_PKT_RX_CRC16_EN
        chk("data0_flip", {ok_a, er_a}, 32'b01);
`else
        chk("data0_flip", {ok_a, er_a}, 32'b10);
`endif

        pk = {8'hC3, 8'h00, 8'h00};
        run(-1);
        chk("zlp_nbytes", q_a.size(), 0);
        chk("zlp_ok", {ok_a, er_a}, 32'b10);

        pk = {8'hC3, 8'h00};
        run(-1);
        chk("short_err", {ok_a, er_a}, 32'b01);

        pk = {8'hD2};
        run(-1);
        chk("ack_pid", 32'(a_if.pid), 32'h2);
        chk("ack_count", 32'(a_if.byte_count), 32'd0);
        chk("ack_ok", {ok_a, er_a}, 32'b10);

        pk = {8'hD2, 8'h00};
        run(-1);
        chk("ack_extra_err", {ok_a, er_a}, 32'b01);

        pk = {8'h2C, 8'h11, 8'h22};
        run(-1);
        chk("badpid_nbytes", q_a.size(), 0);
        chk("badpid_ends", n_end_a - e0, 1);
        chk("badpid_pid", 32'(a_if.pid), 32'h2);
        chk("badpid_err", {ok_a, er_a}, 32'b01);

        pk = {8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run(-1);
        chk("babble_nbytes", q_b.size(), 4);
        chk("babble_last", q_b.size() == 4 ? 32'(q_b[3]) : 32'hFFFF, 32'h04);
        chk("babble_ends", n_end_b - e1, 1);
        chk("babble_err", {ok_b, er_b}, 32'b01);
        chk("big_nbytes", q_a.size(), 5);

        pk = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00};
        run(3);
        chk("rxerr_err", {ok_a, er_a}, 32'b01);

        e0 = n_end_a;
        step();
        s_active = 1'b1;
        step();
        step();
        s_data = 8'hD2;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rstmid_pid", 32'(a_if.pid), 32'h0);
        s_data = 8'h00;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        s_active = 1'b0;
        repeat (8) step();
        chk("rstmid_ends", n_end_a - e0, 0);
        chk("rstmid_outs", {a_if.pkt_ok, a_if.pkt_err,
                            a_if.data_valid, a_if.pkt_end}, 32'h0);

        pk = {8'hD2};
        run(-1);
        chk("rstmid_ack_ends", n_end_a - e0, 1);
        chk("rstmid_ack_ok", {ok_a, er_a}, 32'b10);
        chk("onehot_status", n_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
